video_timing_gen: RTL

//  Programmable raster timing generator: source-side counterpart of video_sync. Produces the raw

---
 rtl/video_timing_gen.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: dot/line counters with hsync/vsync/blank decode and a validated shadow timing set applied at frame wrap.
// Outputs are registered and aligned with dot_x/line_y, one clock after each ce cycle; pause freezes counting, outputs and apply.
module video_timing_gen #(
  parameter int unsigned DEF_H_TOTAL  = 2048,
  parameter int unsigned DEF_H_ACTIVE = 1600,
  parameter int unsigned DEF_HS_START = 1664,
  parameter int unsigned DEF_HS_LEN   = 152,
  parameter int unsigned DEF_V_TOTAL  = 312,
  parameter int unsigned DEF_V_ACTIVE = 270,
  parameter int unsigned DEF_VS_START = 290,
  parameter int unsigned DEF_VS_LEN   = 3
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        ce,
  input  logic        pause,
  input  logic        cfg_load,
  input  logic [11:0] cfg_h_total,
  input  logic [11:0] cfg_h_active,
  input  logic [11:0] cfg_hs_start,
  input  logic [11:0] cfg_hs_len,
  input  logic [8:0]  cfg_v_total,
  input  logic [8:0]  cfg_v_active,
  input  logic [8:0]  cfg_vs_start,
  input  logic [8:0]  cfg_vs_len,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic [11:0] dot_x,
  output logic [8:0]  line_y,
  output logic        frame_start,
  output logic        cfg_err
);

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [11:0] hs_start;
    logic [11:0] hs_len;
    logic [8:0]  v_total;
    logic [8:0]  v_active;
    logic [8:0]  vs_start;
    logic [8:0]  vs_len;
  } timing_t;

  typedef enum logic [1:0] {
    CFG_IDLE    = 2'd0,
    CFG_CHECK   = 2'd1,
    CFG_PENDING = 2'd2
  } cfg_state_t;

  localparam timing_t DEF_SET = '{
    h_total:  12'(DEF_H_TOTAL),
    h_active: 12'(DEF_H_ACTIVE),
    hs_start: 12'(DEF_HS_START),
    hs_len:   12'(DEF_HS_LEN),
    v_total:  9'(DEF_V_TOTAL),
    v_active: 9'(DEF_V_ACTIVE),
    vs_start: 9'(DEF_VS_START),
    vs_len:   9'(DEF_VS_LEN)
  };

  cfg_state_t  cfg_state_q, cfg_state_d;
  timing_t     active_q, active_d;
  timing_t     pending_q, pending_d;
  timing_t     cfg_in;
  timing_t     dec;
  logic [11:0] dot_q, dot_d, dot_nx;
  logic [8:0]  line_q, line_d, line_nx;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblank_q, hblank_d;
  logic        vblank_q, vblank_d;
  logic        frame_start_q, frame_start_d;
  logic        cfg_err_q, cfg_err_d;
  logic        advance, dot_last, line_last, wrap;
  logic        set_bad, cfg_apply;
  logic [12:0] hs_sum;
  logic [9:0]  vs_sum;
  logic [11:0] hs_end;
  logic [8:0]  vs_end;

  assign cfg_in = '{
    h_total:  cfg_h_total,
    h_active: cfg_h_active,
    hs_start: cfg_hs_start,
    hs_len:   cfg_hs_len,
    v_total:  cfg_v_total,
    v_active: cfg_v_active,
    vs_start: cfg_vs_start,
    vs_len:   cfg_vs_len
  };

  assign advance   = ce && !pause;
  assign dot_last  = (dot_q == active_q.h_total - 12'd1);
  assign line_last = (line_q == active_q.v_total - 9'd1);
  assign wrap      = dot_last && line_last;

  always_comb begin
    set_bad = (pending_q.h_total < 12'd64)
           || (pending_q.v_total < 9'd16)
           || (pending_q.h_active > pending_q.h_total)
           || (pending_q.v_active > pending_q.v_total)
           || (pending_q.hs_start >= pending_q.h_total)
           || (pending_q.hs_len >= pending_q.h_total)
           || (pending_q.vs_start >= pending_q.v_total)
           || (pending_q.vs_len >= pending_q.v_total);
  end

  // Config FSM: state register
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      cfg_state_q <= CFG_IDLE;
    end else begin
      cfg_state_q <= cfg_state_d;
    end
  end

  // Config FSM: next state; a fresh load always restarts validation
  always_comb begin
    cfg_state_d = cfg_state_q;
    unique case (cfg_state_q)
      CFG_IDLE: begin
        if (cfg_load) cfg_state_d = CFG_CHECK;
      end
      CFG_CHECK: begin
        if (cfg_load)     cfg_state_d = CFG_CHECK;
        else if (set_bad) cfg_state_d = CFG_IDLE;
        else              cfg_state_d = CFG_PENDING;
      end
      CFG_PENDING: begin
        if (cfg_load)       cfg_state_d = CFG_CHECK;
        else if (cfg_apply) cfg_state_d = CFG_IDLE;
      end
      default: cfg_state_d = CFG_IDLE;
    endcase
  end

  // Config FSM: outputs. A load on the wrap cycle still applies the old pending set.
  always_comb begin
    cfg_apply = (cfg_state_q == CFG_PENDING) && advance && wrap;
    cfg_err_d = (cfg_state_q == CFG_CHECK) && !cfg_load && set_bad;
    pending_d = cfg_load ? cfg_in : pending_q;
  end

  always_comb begin
    dot_nx  = dot_q + 12'd1;
    line_nx = line_q;
    if (dot_last) begin
      dot_nx  = '0;
      line_nx = line_last ? '0 : line_q + 9'd1;
    end
  end

  // Decode against the set that will be live for the next counter value
  always_comb begin
    dec    = cfg_apply ? pending_q : active_q;
    hs_sum = {1'b0, dec.hs_start} + {1'b0, dec.hs_len};
    vs_sum = {1'b0, dec.vs_start} + {1'b0, dec.vs_len};
    hs_end = dec.hs_start + dec.hs_len - ((hs_sum >= {1'b0, dec.h_total}) ? dec.h_total : 12'd0);
    vs_end = dec.vs_start + dec.vs_len - ((vs_sum >= {1'b0, dec.v_total}) ? dec.v_total : 9'd0);
  end

  always_comb begin
    dot_d         = dot_q;
    line_d        = line_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    frame_start_d = frame_start_q;
    active_d      = active_q;
    if (!pause) begin
      frame_start_d = 1'b0;
      if (ce) begin
        dot_d         = dot_nx;
        line_d        = line_nx;
        frame_start_d = wrap;
        hblank_d      = (dot_nx >= dec.h_active);
        vblank_d      = (line_nx >= dec.v_active);
        if (cfg_apply) begin
          active_d = pending_q;
          hsync_d  = 1'b0;
          vsync_d  = 1'b0;
        end else begin
          if (dec.hs_len == '0)              hsync_d = 1'b0;
          else if (dot_nx == dec.hs_start)   hsync_d = 1'b1;
          else if (dot_nx == hs_end)         hsync_d = 1'b0;
          // vsync edges are aligned to the hsync rising dot
          if (dec.vs_len == '0)              vsync_d = 1'b0;
          else if (dot_nx == dec.hs_start) begin
            if (line_nx == dec.vs_start)     vsync_d = 1'b1;
            else if (line_nx == vs_end)      vsync_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      active_q      <= DEF_SET;
      pending_q     <= DEF_SET;
      dot_q         <= '0;
      line_q        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      active_q      <= active_d;
      pending_q     <= pending_d;
      dot_q         <= dot_d;
      line_q        <= line_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign dot_x       = dot_q;
  assign line_y      = line_q;
  assign frame_start = frame_start_q;
  assign cfg_err     = cfg_err_q;

endmodule
